median_window_ctrl: RTL and testbench

Sequencer for the two 8-bit line-buffer FIFOs (depth `LINE_DEPTH`, 2-cycle read latency, active-high async reset) that feed the 3×3 window of the salt-and-pepper median filter. The block counts raster position and drives write/read enables and clears for both FIFOs, so each FIFO delays its stream by exactly one image line. It tells the window datapath when to shift and when the window holds a complete, valid neighbourhood, and it flags border pixels. The block sits between the pixel input stream and the window/median datapath; it carries no pixel data itself.

---
 rtl/median_pkg.sv | 17 +
 rtl/occ_counter.sv | 37 +++
 rtl/median_window_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_median_window_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and default geometry for the median-filter window controller.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_t;

  localparam int unsigned IMG_WIDTH_DEF  = 256;
  localparam int unsigned IMG_HEIGHT_DEF = 256;
  localparam int unsigned LINE_DEPTH_DEF = IMG_WIDTH_DEF - 3;

  typedef logic [7:0] pix_t;

endpackage

// File: rtl/occ_counter.sv
// Saturating occupancy tracker for one line-buffer FIFO. The FIFO is read
// exactly when it is full, so a write while full leaves occupancy unchanged.
module occ_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] sat_level,
  output logic          full
);

  logic [CW-1:0] occ_q, occ_d;

  assign full = (occ_q == sat_level);

  // next occupancy: clear wins, otherwise count writes until saturation
  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (inc && !full) begin
      occ_d = occ_q + CW'(1);
    end
  end

  // occupancy register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/median_window_ctrl.sv
// Raster sequencer for the two line-buffer FIFOs and the 3x3 window of the
// median filter. Carries no pixel data.
//
//   state | meaning
//   IDLE  | waiting for start, pix_valid ignored
//   FILL  | priming line buffers until pixel (2,0) is accepted
//   RUN   | streaming until pixel (H-1,W-1) is accepted
//   FLUSH | W+1 virtual pixels to emit the last output row
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned LINE_DEPTH = IMG_WIDTH - 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          pix_valid,
  output logic                          busy,
  output logic                          lb_clr,
  output logic                          lb0_wr_en,
  output logic                          lb0_rd_en,
  output logic                          lb1_wr_en,
  output logic                          lb1_rd_en,
  output logic                          win_shift,
  output logic                          win_valid,
  output logic                          border,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          frame_done
);

  localparam int unsigned CW  = $clog2(IMG_WIDTH);
  localparam int unsigned RW  = $clog2(IMG_HEIGHT + 2);
  localparam int unsigned ORW = $clog2(IMG_HEIGHT);
  localparam int unsigned OCW = $clog2(LINE_DEPTH + 1);
  localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0]  ROW_VEND  = RW'(IMG_HEIGHT + 1);
  localparam logic [ORW-1:0] OROW_LAST = ORW'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic           acc;
    logic           valid;
    logic           last;
    logic [ORW-1:0] row;
    logic [CW-1:0]  col;
  } stage_t;

  ctrl_state_t    state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  stage_t         s1_q, s1_d, s2_q, s2_d;
  logic           win_valid_q, win_valid_d;
  logic           border_q, border_d;
  logic           frame_done_q, frame_done_d;
  logic [ORW-1:0] out_row_q, out_row_d;
  logic [CW-1:0]  out_col_q, out_col_d;

  logic           accepted, last_acc, lb1_full, lb0_full;
  logic           ctr_valid;
  logic [ORW-1:0] ctr_row;
  logic [CW-1:0]  ctr_col;

  // acceptance strobe and FIFO enables, combinational in the acceptance cycle
  always_comb begin
    accepted = 1'b0;
    if (rst) begin
      accepted = (state_q == FLUSH) ||
                 (pix_valid && (state_q == FILL || state_q == RUN));
    end
    last_acc  = accepted && (state_q == FLUSH) && (row_q == ROW_VEND) && (col_q == '0);
    lb1_wr_en = accepted;
    lb1_rd_en = accepted && lb1_full;
    // lb0 is fed from the row-1 window output, which is meaningful once a full line has gone through lb1
    lb0_wr_en = accepted && (row_q != '0);
    lb0_rd_en = lb0_wr_en && lb0_full;
    busy      = rst && (state_q != IDLE);
    lb_clr    = !rst || (state_q == IDLE && start);
  end

  occ_counter #(.CW(OCW)) u_occ1 (
    .clk       (clk),
    .rst       (rst),
    .clr       (lb_clr),
    .inc       (lb1_wr_en),
    .sat_level (OCW'(LINE_DEPTH)),
    .full      (lb1_full)
  );

  occ_counter #(.CW(OCW)) u_occ0 (
    .clk       (clk),
    .rst       (rst),
    .clr       (lb_clr),
    .inc       (lb0_wr_en),
    .sat_level (OCW'(LINE_DEPTH)),
    .full      (lb0_full)
  );

  // window centre trails the accepted pixel by one line plus one pixel in raster order;
  // a column-0 pixel therefore centres on the last column two rows up
  always_comb begin
    ctr_valid = (row_q >= RW'(2)) || (row_q == RW'(1) && col_q != '0);
    if (col_q == '0) begin
      ctr_row = ORW'(row_q - RW'(2));
      ctr_col = COL_LAST;
    end else begin
      ctr_row = ORW'(row_q - RW'(1));
      ctr_col = col_q - CW'(1);
    end
  end

  // next-state and raster position
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (accepted) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FILL:  if (accepted && row_q == RW'(2) && col_q == '0) state_d = RUN;
      RUN:   if (accepted && row_q == ROW_LAST && col_q == COL_LAST) state_d = FLUSH;
      FLUSH: begin
        if (last_acc) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // two-stage delay matching FIFO read latency, then the window output stage
  always_comb begin
    s1_d.acc     = accepted;
    s1_d.valid   = accepted && ctr_valid;
    s1_d.last    = last_acc;
    s1_d.row     = ctr_row;
    s1_d.col     = ctr_col;
    s2_d         = s1_q;
    win_valid_d  = s2_q.valid;
    out_row_d    = s2_q.valid ? s2_q.row : '0;
    out_col_d    = s2_q.valid ? s2_q.col : '0;
    border_d     = s2_q.valid && (s2_q.row == '0 || s2_q.row == OROW_LAST ||
                                  s2_q.col == '0 || s2_q.col == COL_LAST);
    frame_done_d = s2_q.last;
  end

  // all registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      win_valid_q  <= 1'b0;
      border_q     <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      win_valid_q  <= win_valid_d;
      border_q     <= border_d;
      frame_done_q <= frame_done_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
    end
  end

  assign win_shift  = s2_q.acc;
  assign win_valid  = win_valid_q;
  assign border     = border_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl at W=8, H=6 (line depth 5).
// The reference model tracks each frame as a linear pixel index and derives
// enables and window centres arithmetically from it.
module tb_median_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int LD = W - 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pix_valid;
  logic       busy, lb_clr;
  logic       lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en;
  logic       win_shift, win_valid, border, frame_done;
  logic [2:0] out_row;
  logic [2:0] out_col;

  median_window_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_valid  (pix_valid),
    .busy       (busy),
    .lb_clr     (lb_clr),
    .lb0_wr_en  (lb0_wr_en),
    .lb0_rd_en  (lb0_rd_en),
    .lb1_wr_en  (lb1_wr_en),
    .lb1_rd_en  (lb1_rd_en),
    .win_shift  (win_shift),
    .win_valid  (win_valid),
    .border     (border),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit acc;
    bit valid;
    bit done;
    bit brd;
    int row;
    int col;
  } hist_t;

  int    checks = 0;
  int    errors = 0;
  int    m_act  = 0;
  int    m_p    = 0;
  int    n_valid = 0;
  int    n_done  = 0;
  hist_t h1, h2, h3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_act = 0;
    m_p   = 0;
    h1 = '{acc: 0, valid: 0, done: 0, brd: 0, row: 0, col: 0};
    h2 = h1;
    h3 = h1;
  endtask

  // one clock cycle: drive, check mid-cycle, advance the reference model
  task automatic step(input bit v, input bit s, input bit r);
    bit    acc;
    hist_t nh;
    int    q;
    pix_valid = v;
    start     = s;
    rst       = r;
    @(negedge clk);
    acc = r && (m_act != 0) && (m_p >= H*W || v);
    chk("busy",   busy,   32'(r && m_act != 0));
    chk("lb_clr", lb_clr, 32'(!r || (m_act == 0 && s)));
    chk("lb_enables", {lb1_wr_en, lb1_rd_en, lb0_wr_en, lb0_rd_en},
        {acc, acc && m_p >= LD, acc && m_p >= W, acc && m_p >= W + LD});
    chk("win_shift",  win_shift,  32'(h2.acc));
    chk("win_valid",  win_valid,  32'(h3.valid));
    chk("out_row",    out_row,    h3.valid ? h3.row : 0);
    chk("out_col",    out_col,    h3.valid ? h3.col : 0);
    chk("border",     border,     32'(h3.brd));
    chk("frame_done", frame_done, 32'(h3.done));
    if (win_valid === 1'b1) n_valid++;
    if (frame_done === 1'b1) n_done++;
    @(posedge clk);
    #1;
    q        = m_p - W - 1;
    nh.acc   = acc;
    nh.valid = acc && (m_p >= W + 1);
    nh.row   = nh.valid ? q / W : 0;
    nh.col   = nh.valid ? q % W : 0;
    nh.brd   = nh.valid && (nh.row == 0 || nh.row == H-1 || nh.col == 0 || nh.col == W-1);
    nh.done  = acc && (m_p == H*W + W);
    h3 = h2;
    h2 = h1;
    h1 = nh;
    if (acc) begin
      m_p++;
      if (m_p > H*W + W) m_act = 0;
    end else if (r && m_act == 0 && s) begin
      m_act = 1;
      m_p   = 0;
    end
    if (!r) clear_model();
  endtask

  // mode 0: continuous, 1: alternating gaps, 2: random gaps plus stray starts
  task automatic run_frame(input int mode);
    bit v, s;
    n_valid = 0;
    n_done  = 0;
    step(0, 1, 1);
    for (int k = 0; k < 600 && m_act != 0; k++) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : bit'($urandom_range(0, 1));
      s = (mode == 2) && ($urandom_range(0, 5) == 0);
      step(v, s, 1);
    end
    chk("frame_end", m_act, 0);
    repeat (4) step(0, 0, 1);
    chk("valid_count", n_valid, W*H);
    chk("done_count",  n_done,  1);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    pix_valid = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    step(1, 1, 0);
    step(0, 0, 0);
    repeat (2) step(0, 0, 1);

    // start with no pixels: busy, no enables
    step(0, 1, 1);
    repeat (3) step(0, 0, 1);
    chk("busy_waiting", busy, 1);
    for (int k = 0; k < 600 && m_act != 0; k++) step(1, 0, 1);
    chk("frame_end", m_act, 0);
    repeat (4) step(0, 0, 1);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(2);

    // reset in the cycle pixel (3,2) would be accepted
    step(0, 1, 1);
    for (int k = 0; k < 100 && m_p < 3*W + 2; k++) step(1, 0, 1);
    chk("reset_point", m_p, 3*W + 2);
    step(1, 0, 0);
    step(1, 0, 1);
    chk("busy_after_reset", busy, 0);
    repeat (2) step(0, 0, 1);
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
